axis2fifo_pack: RTL and testbench
=================================

Name: axis2fifo_pack

Overview:
Parametrised AXI4-Stream to FIFO-write packer; next generation of the stream-to-FIFO front end in the template app.
- Gates capture on a TUSER start marker.
- Packs RATIO narrow beats into one wide FIFO word, flushing partial words on TLAST with zero padding and a lane mask.
- Applies real backpressure from the FIFO's ready, full and fill-count signals.
- Sits between an AXIS source and the wide write port of the address/data FIFO.

Parameters:
FAW, 8, FIFO depth is 2^FAW; width of fwr_cnt is FAW+1.
AXIS_DATA_WIDTH, 32, sink beat width in bits; multiple of 8.
AXI4_DATA_WIDTH, 128, FIFO word width; integer multiple of AXIS_DATA_WIDTH, RATIO = AXI4_DATA_WIDTH/AXIS_DATA_WIDTH, RATIO >= 2.
FULL_MARGIN, 2, TREADY deasserts when fwr_cnt >= 2^FAW - FULL_MARGIN; range 0..2^FAW-1.

Ports:
S_AXIS_ACLK  in  1  single clock for the whole block.
S_AXIS_ARESET  in  1  synchronous, active-high reset.
S_AXIS_TVALID  in  1  beat valid.
S_AXIS_TREADY  out  1  beat accepted when TVALID & TREADY.
S_AXIS_TDATA  in  AXIS_DATA_WIDTH  beat payload.
S_AXIS_TSTRB  in  AXIS_DATA_WIDTH/8  ignored; the whole beat is always packed.
S_AXIS_TLAST  in  1  frame end; forces flush.
S_AXIS_USER  in  1  capture-start marker.
fwr_rdy  in  1  FIFO write ready.
fwr_full  in  1  FIFO full.
fwr_cnt  in  FAW+1  FIFO fill count.
fwr_vld  out  1  write request; registered.
fwr_dat  out  AXI4_DATA_WIDTH  packed word; registered.
fwr_keep  out  RATIO  per-lane valid mask.
fwr_last  out  1  word ends a frame.

Behaviour:
- Reset:
  - fwr_vld, fwr_dat, fwr_keep and fwr_last are 0.
  - Lane counter is 0, pack buffer is 0, state is WAIT_SOF.
  - Reset asserted mid-frame discards any partial word and any held output word.
- Accept: acc = TVALID & TREADY.
- Transfer: xfer = fwr_vld & fwr_rdy & ~fwr_full.
- TREADY = ~(fwr_vld & ~xfer) & (fwr_cnt < 2^FAW - FULL_MARGIN).
  - It is combinational from the fwr_* inputs and the registered state only, with no dependence on TVALID.
  - The output register may be refilled in the same cycle it drains.
- State machine:
  - WAIT_SOF:
    - Beats are accepted, not dropped by stalling, and discarded unless USER=1.
    - An accepted beat with USER=1 is packed as lane 0 and the state moves to PACK.
    - If that beat also has TLAST, the word is flushed immediately.
  - PACK:
    - Every accepted beat is packed; USER is ignored.
    - The block stays in PACK permanently until reset. This is the sticky capture window.
- Packing order: first beat of a word goes in the most-significant lane; lane i occupies bits [AXI4_DATA_WIDTH-1-i*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH].
- Lane counter runs 0..RATIO-1 and wraps to 0 on every emit. There is no RATIO+1 count state.
- Emit happens on an accepted beat when lane==RATIO-1 or TLAST=1. On the next cycle:
  - fwr_vld=1.
  - fwr_dat holds the packed word; unfilled lanes are 0.
  - fwr_keep has bit i=1 for each filled lane, MSB-first, so bit RATIO-1 is lane 0.
  - fwr_last = TLAST.
- Latency: emitting beat to fwr_vld is one cycle.
- Hold: fwr_vld and its data stay stable until xfer. On xfer with no new emit, fwr_vld=0 and fwr_dat/keep/last=0.
- TLAST on lane 0 emits a single-lane word with keep = 1 << (RATIO-1).
- fwr_full=1 with fwr_rdy=1 is not a transfer; the word is held.

Optional Feature:
AXIS2FIFO_PACK_STAT_EN.
- Defined: adds outputs stat_words[31:0], stat_frames[31:0] and stat_drop[31:0], plus input stat_clr.
  - stat_words counts xfer events.
  - stat_frames counts xfer with fwr_last.
  - stat_drop counts beats discarded in WAIT_SOF.
  - All counters saturate at all-ones, clear on reset or stat_clr, and stat_clr has priority over an increment in the same cycle.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package axis2fifo_pkg:
  - State encoding constants WAIT_SOF=1'b0, PACK=1'b1.
  - RATIO and lane-counter-width helper functions (clog2 with minimum 1).
- Sub-module axis2fifo_pack_buf: lane shift/insert register with counter and keep generation, driven by accept and emit.
- Top module holds the FSM, the TREADY logic, the output register and the optional stats.

Test Plan:
- Defaults. Reset, USER=1 on first beat, then 8 beats 0x00000001..0x00000008, TLAST on the 8th, fwr_rdy=1 → two writes, 0x00000001_00000002_00000003_00000004 keep=4'b1111 last=0, and 0x00000005_..._00000008 keep=4'b1111 last=1; each fwr_vld one cycle after the 4th/8th beat.
- Three beats with USER=0, then A,B,C with USER on A and TLAST on C → exactly one write, 0xA_B_C_0 (lanes zero-padded) keep=4'b1110 last=1; stat_drop=3 when the stat feature is enabled.
- fwr_rdy=0 while a word is pending → TREADY=0; the 4 beats behind it stall, fwr_dat stays constant; after fwr_rdy=1, the held word transfers, then the next word appears, with no loss or duplication.
- fwr_cnt=254 (FAW=8, FULL_MARGIN=2) → TREADY=0 and no accept; fwr_cnt=253 → TREADY=1.
- Assert S_AXIS_ARESET for one cycle after 2 beats of a word → outputs 0, state WAIT_SOF; subsequent beats without USER produce no write.
- Back-to-back frames of 1, 5 and 4 beats at full throughput → keep values 4'b1000; 4'b1111 then 4'b1000; 4'b1111, each frame's final word with last=1. Zero idle cycles on TREADY.

Source files
------------

// File: rtl/axis2fifo_pkg.sv
// Shared state encoding and sizing helpers for the AXI4-Stream to FIFO-write packer.
package axis2fifo_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        PACK     = 1'b1
    } state_e;

    function automatic int pack_ratio(input int word_w, input int beat_w);
        return word_w / beat_w;
    endfunction

    // A lane counter always needs at least one bit, even for degenerate ratios.
    function automatic int lane_cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/axis2fifo_pack_buf.sv
// Lane pack buffer: inserts accepted beats MSB-lane first and presents the word plus lane mask for emit.
module axis2fifo_pack_buf
    import axis2fifo_pkg::*;
#(
    parameter int BEAT_W = 32,
    parameter int WORD_W = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc,
    input  logic                       emit,
    input  logic [BEAT_W-1:0]          beat,
    output logic [WORD_W-1:0]          word,
    output logic [WORD_W/BEAT_W-1:0]   keep,
    output logic                       lane_last
);

    localparam int RATIO = pack_ratio(WORD_W, BEAT_W);
    localparam int LW    = lane_cnt_width(RATIO);
    localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [LW-1:0]     lane_q, lane_d;

    assign lane_last = (lane_q == LANE_MAX);

    // Word as it would look with the incoming beat dropped into the current lane.
    always_comb begin
        word = buf_q;
        keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_q == LW'(i)) begin
                word[WORD_W-1-i*BEAT_W -: BEAT_W] = beat;
            end
            if (LW'(i) <= lane_q) begin
                keep[RATIO-1-i] = 1'b1;
            end
        end
    end

    always_comb begin
        buf_d  = buf_q;
        lane_d = lane_q;
        if (acc) begin
            if (emit) begin
                buf_d  = '0;
                lane_d = '0;
            end else begin
                buf_d  = word;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            lane_q <= '0;
        end else begin
            buf_q  <= buf_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/axis2fifo_pack.sv
// AXI4-Stream to wide FIFO-write packer with TUSER capture gating and registered write port.
// Optional statistics counters are built when AXIS2FIFO_PACK_STAT_EN is defined.
module axis2fifo_pack
    import axis2fifo_pkg::*;
#(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int FULL_MARGIN     = 2
) (
    input  logic                                         S_AXIS_ACLK,
    input  logic                                         S_AXIS_ARESET,
    input  logic                                         S_AXIS_TVALID,
    output logic                                         S_AXIS_TREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]                   S_AXIS_TDATA,
    input  logic [AXIS_DATA_WIDTH/8-1:0]                 S_AXIS_TSTRB,
    input  logic                                         S_AXIS_TLAST,
    input  logic                                         S_AXIS_USER,
    input  logic                                         fwr_rdy,
    input  logic                                         fwr_full,
    input  logic [FAW:0]                                 fwr_cnt,
    output logic                                         fwr_vld,
    output logic [AXI4_DATA_WIDTH-1:0]                   fwr_dat,
    output logic [AXI4_DATA_WIDTH/AXIS_DATA_WIDTH-1:0]   fwr_keep,
    output logic                                         fwr_last
`ifdef AXIS2FIFO_PACK_STAT_EN
    ,
    input  logic                                         stat_clr,
    output logic [31:0]                                  stat_words,
    output logic [31:0]                                  stat_frames,
    output logic [31:0]                                  stat_drop
`endif
);

    localparam int RATIO = pack_ratio(AXI4_DATA_WIDTH, AXIS_DATA_WIDTH);
    localparam logic [FAW:0] FULL_LEVEL = (FAW + 1)'((2 ** FAW) - FULL_MARGIN);

    state_e                        state_q, state_d;
    logic                          vld_q, vld_d;
    logic [AXI4_DATA_WIDTH-1:0]    dat_q, dat_d;
    logic [RATIO-1:0]              keep_q, keep_d;
    logic                          last_q, last_d;

    logic                          xfer;
    logic                          acc;
    logic                          pack_acc;
    logic                          emit;
    logic                          lane_last;
    logic [AXI4_DATA_WIDTH-1:0]    pack_word;
    logic [RATIO-1:0]              pack_keep;

    logic                          unused_tstrb;
    assign unused_tstrb = ^S_AXIS_TSTRB;

    // Ready depends only on registered state and FIFO status, so a draining word frees the slot at once.
    assign xfer          = vld_q & fwr_rdy & ~fwr_full;
    assign S_AXIS_TREADY = ~(vld_q & ~xfer) & (fwr_cnt < FULL_LEVEL);
    assign acc           = S_AXIS_TVALID & S_AXIS_TREADY;
    assign pack_acc      = acc & ((state_q == PACK) | S_AXIS_USER);
    assign emit          = pack_acc & (lane_last | S_AXIS_TLAST);

    axis2fifo_pack_buf #(
        .BEAT_W (AXIS_DATA_WIDTH),
        .WORD_W (AXI4_DATA_WIDTH)
    ) u_buf (
        .clk       (S_AXIS_ACLK),
        .rst       (S_AXIS_ARESET),
        .acc       (pack_acc),
        .emit      (emit),
        .beat      (S_AXIS_TDATA),
        .word      (pack_word),
        .keep      (pack_keep),
        .lane_last (lane_last)
    );

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if ((state_q == WAIT_SOF) && acc && S_AXIS_USER) begin
            state_d = PACK;
        end
        if (emit) begin
            vld_d  = 1'b1;
            dat_d  = pack_word;
            keep_d = pack_keep;
            last_d = S_AXIS_TLAST;
        end else if (xfer) begin
            vld_d  = 1'b0;
            dat_d  = '0;
            keep_d = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q <= WAIT_SOF;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign fwr_vld  = vld_q;
    assign fwr_dat  = dat_q;
    assign fwr_keep = keep_q;
    assign fwr_last = last_q;

`ifdef AXIS2FIFO_PACK_STAT_EN
    logic        drop;
    logic [31:0] words_q, words_d;
    logic [31:0] frames_q, frames_d;
    logic [31:0] drop_q, drop_d;

    assign drop = acc & (state_q == WAIT_SOF) & ~S_AXIS_USER;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        words_d  = stat_clr ? '0 : sat_inc(words_q, xfer);
        frames_d = stat_clr ? '0 : sat_inc(frames_q, xfer & last_q);
        drop_d   = stat_clr ? '0 : sat_inc(drop_q, drop);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            words_q  <= '0;
            frames_q <= '0;
            drop_q   <= '0;
        end else begin
            words_q  <= words_d;
            frames_q <= frames_d;
            drop_q   <= drop_d;
        end
    end

    assign stat_words  = words_q;
    assign stat_frames = frames_q;
    assign stat_drop   = drop_q;
`endif

endmodule

// File: tb/tb_axis2fifo_pack.sv
// Directed plus randomised bench for axis2fifo_pack, checked against a queue-based frame model.
module tb_axis2fifo_pack;

    localparam int FAW        = 8;
    localparam int BW         = 32;
    localparam int WW         = 128;
    localparam int RATIO      = WW / BW;
    localparam int MARGIN     = 2;
    localparam int FULL_LEVEL = (1 << FAW) - MARGIN;

    logic              clk = 1'b0;
    logic              rst;
    logic              tvalid;
    logic              tready;
    logic [BW-1:0]     tdata;
    logic [BW/8-1:0]   tstrb;
    logic              tlast;
    logic              tuser;
    logic              rdy;
    logic              full;
    logic [FAW:0]      cnt;
    logic              vld;
    logic [WW-1:0]     dat;
    logic [RATIO-1:0]  keep;
    logic              last;
`ifdef AXIS2FIFO_PACK_STAT_EN
    logic              stat_clr;
    logic [31:0]       stat_words;
    logic [31:0]       stat_frames;
    logic [31:0]       stat_drop;
`endif

    always #5 clk = ~clk;

    axis2fifo_pack #(
        .FAW             (FAW),
        .AXIS_DATA_WIDTH (BW),
        .AXI4_DATA_WIDTH (WW),
        .FULL_MARGIN     (MARGIN)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_USER   (tuser),
        .fwr_rdy       (rdy),
        .fwr_full      (full),
        .fwr_cnt       (cnt),
        .fwr_vld       (vld),
        .fwr_dat       (dat),
        .fwr_keep      (keep),
        .fwr_last      (last)
`ifdef AXIS2FIFO_PACK_STAT_EN
        ,
        .stat_clr      (stat_clr),
        .stat_words    (stat_words),
        .stat_frames   (stat_frames),
        .stat_drop     (stat_drop)
`endif
    );

    // Reference model: captured flag, beats of the word in progress, and the one word awaiting the FIFO.
    logic [BW-1:0]     m_beats[$];
    bit                m_captured;
    bit                m_acc;
    bit                m_pend_vld;
    logic [WW-1:0]     m_pend_dat;
    logic [RATIO-1:0]  m_pend_keep;
    bit                m_pend_last;
`ifdef AXIS2FIFO_PACK_STAT_EN
    int                m_words;
    int                m_frames;
    int                m_drops;
`endif

    int                checks = 0;
    int                passed = 0;
    int                dut_xfers = 0;
    int                tready_low = 0;
    logic [RATIO:0]    xfer_log[$];
    logic              obs_tready;

    task automatic chk(input string tag, input logic [WW-1:0] observed, input logic [WW-1:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    function automatic bit expTready();
        return !(m_pend_vld && !(rdy && !full)) && (int'(cnt) < FULL_LEVEL);
    endfunction

    task automatic clearPend();
        m_pend_vld  = 1'b0;
        m_pend_dat  = '0;
        m_pend_keep = '0;
        m_pend_last = 1'b0;
    endtask

    task automatic applyStimulus(input bit v, input logic [BW-1:0] d, input bit l, input bit u,
                                 input bit r, input bit f, input int c, input bit rs);
        tvalid = v;
        tdata  = d;
        tstrb  = 4'($urandom);
        tlast  = l;
        tuser  = u;
        rdy    = r;
        full   = f;
        cnt    = (FAW + 1)'(c);
        rst    = rs;
    endtask

    task automatic checkOutput();
        obs_tready = tready;
        chk("tready", tready, expTready());
        chk("fwr_vld", vld, m_pend_vld);
        chk("fwr_dat", dat, m_pend_dat);
        chk("fwr_keep", keep, m_pend_keep);
        chk("fwr_last", last, m_pend_last);
`ifdef AXIS2FIFO_PACK_STAT_EN
        chk("stat_words", stat_words, m_words);
        chk("stat_frames", stat_frames, m_frames);
        chk("stat_drop", stat_drop, m_drops);
`endif
        if (vld && rdy && !full) begin
            dut_xfers++;
            xfer_log.push_back({keep, last});
        end
        if (!tready) tready_low++;
    endtask

    task automatic modelUpdate();
        logic [WW-1:0] acc_word;
        int            n;
        m_acc = tvalid && expTready();
        if (rst) begin
            m_beats.delete();
            m_captured = 1'b0;
            m_acc      = 1'b0;
            clearPend();
`ifdef AXIS2FIFO_PACK_STAT_EN
            m_words  = 0;
            m_frames = 0;
            m_drops  = 0;
`endif
            return;
        end
        if (m_pend_vld && rdy && !full) begin
`ifdef AXIS2FIFO_PACK_STAT_EN
            m_words++;
            if (m_pend_last) m_frames++;
`endif
            clearPend();
        end
        if (m_acc) begin
            if (!m_captured && !tuser) begin
`ifdef AXIS2FIFO_PACK_STAT_EN
                m_drops++;
`endif
            end else begin
                m_captured = 1'b1;
                m_beats.push_back(tdata);
                if (m_beats.size() == RATIO || tlast) begin
                    n = m_beats.size();
                    acc_word = '0;
                    foreach (m_beats[k]) acc_word = (acc_word << BW) | WW'(m_beats[k]);
                    m_pend_vld  = 1'b1;
                    m_pend_dat  = acc_word << ((RATIO - n) * BW);
                    m_pend_keep = RATIO'(((1 << n) - 1) << (RATIO - n));
                    m_pend_last = tlast;
                    m_beats.delete();
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [BW-1:0] d, input bit l, input bit u,
                         input bit r, input bit f, input int c, input bit rs, input bit do_chk);
        applyStimulus(v, d, l, u, r, f, c, rs);
        #1;
        if (do_chk) checkOutput();
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic sendBeat(input logic [BW-1:0] d, input bit l, input bit u, input bit r, input int c);
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, d, l, u, r, 1'b0, c, 1'b0, 1'b1);
            tries++;
        end while (!m_acc && tries < 50);
        if (!m_acc) begin
            checks++;
            $error("FAIL beat_timeout: observed=not accepted expected=accepted");
        end
    endtask

    initial begin
        bit            hv, hl, hu, r, f, rs;
        logic [BW-1:0] hd;
        int            c;
        int            base;
        int            lens[3];
        logic [RATIO:0] exp_log[4];

        clearPend();
        m_captured = 1'b0;
        m_acc      = 1'b0;
`ifdef AXIS2FIFO_PACK_STAT_EN
        m_words  = 0;
        m_frames = 0;
        m_drops  = 0;
        stat_clr = 1'b0;
`endif
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(1);

        // Two full words from one eight-beat frame.
        base = dut_xfers;
        for (int i = 1; i <= 8; i++) sendBeat(BW'(i), i == 8, i == 1, 1'b1, 0);
        idle(3);
        chk("t1_words", dut_xfers - base, 2);

        // Pre-capture beats are discarded; partial word is zero padded.
        doReset();
        base = dut_xfers;
        for (int i = 0; i < 3; i++) sendBeat(BW'($urandom), 1'b0, 1'b0, 1'b1, 0);
        sendBeat(32'hA, 1'b0, 1'b1, 1'b1, 0);
        sendBeat(32'hB, 1'b0, 1'b0, 1'b1, 0);
        sendBeat(32'hC, 1'b1, 1'b0, 1'b1, 0);
        idle(3);
        chk("t2_words", dut_xfers - base, 1);
        chk("t2_keep_last", xfer_log[$], {4'b1110, 1'b1});
`ifdef AXIS2FIFO_PACK_STAT_EN
        chk("t2_stat_drop", stat_drop, 3);
`endif

        // FIFO not ready while a word is held.
        doReset();
        base = dut_xfers;
        for (int i = 1; i <= 4; i++) sendBeat(BW'(32'h100 + i), 1'b0, i == 1, 1'b0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h105, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("t3_tready_stall", obs_tready, 1'b0);
        cycle(1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        chk("t3_full_holds", obs_tready, 1'b0);
        for (int i = 5; i <= 8; i++) sendBeat(BW'(32'h100 + i), i == 8, 1'b0, 1'b1, 0);
        idle(3);
        chk("t3_words", dut_xfers - base, 2);

        // Fill-count threshold.
        cycle(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 254, 1'b0, 1'b1);
        chk("t4_tready_254", obs_tready, 1'b0);
        sendBeat(32'h99, 1'b1, 1'b0, 1'b1, 253);
        chk("t4_tready_253", obs_tready, 1'b1);
        idle(2);

        // Reset in the middle of a word, then beats without a start marker.
        doReset();
        sendBeat(32'h11, 1'b0, 1'b1, 1'b1, 0);
        sendBeat(32'h22, 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        base = dut_xfers;
        for (int i = 0; i < 4; i++) sendBeat(BW'(32'h30 + i), i == 3, 1'b0, 1'b1, 0);
        idle(2);
        chk("t5_words", dut_xfers - base, 0);
        chk("t5_vld", vld, 1'b0);

        // Back-to-back frames at full rate.
        doReset();
        xfer_log.delete();
        lens = '{1, 5, 4};
        exp_log = '{{4'b1000, 1'b1}, {4'b1111, 1'b0}, {4'b1000, 1'b1}, {4'b1111, 1'b1}};
        tready_low = 0;
        for (int fidx = 0; fidx < 3; fidx++)
            for (int b = 0; b < lens[fidx]; b++)
                sendBeat(BW'($urandom), b == lens[fidx] - 1, fidx == 0 && b == 0, 1'b1, 0);
        chk("t6_tready_low", tready_low, 0);
        idle(2);
        chk("t6_word_count", xfer_log.size(), 4);
        for (int i = 0; i < 4 && i < xfer_log.size(); i++) chk("t6_keep_last", xfer_log[i], exp_log[i]);

        // Random traffic with AXIS-compliant source holding.
        doReset();
        hv = 1'b0; hd = '0; hl = 1'b0; hu = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!hv) begin
                hv = $urandom_range(0, 99) < 70;
                hd = $urandom;
                hl = $urandom_range(0, 99) < 15;
                hu = $urandom_range(0, 99) < 10;
            end
            r  = $urandom_range(0, 99) < 75;
            f  = $urandom_range(0, 99) < 10;
            rs = $urandom_range(0, 999) < 5;
            c  = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 200)) : int'($urandom_range(250, 256));
            cycle(hv, hd, hl, hu, r, f, c, rs, 1'b1);
            if (m_acc) hv = 1'b0;
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
